// File: rtl/core_pkg.sv
// Shared constants and result payload for the integer writeback path.
package core_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned NREG      = 32;
    localparam int unsigned REG_IDX_W = $clog2(NREG);

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // One completed result headed for the register file.
    typedef struct packed {
        reg_idx_t          rd;
        logic [XLEN-1:0]   data;
    } wb_result_t;

endpackage

// File: rtl/writeback_unit_if.sv
// Producer, issue/query and register-file write signals of the writeback unit.
interface writeback_unit_if;
    import core_pkg::*;

    logic            alu_valid;
    logic            alu_ready;
    reg_idx_t        alu_rd;
    logic [XLEN-1:0] alu_data;

    logic            mem_valid;
    logic            mem_ready;
    reg_idx_t        mem_rd;
    logic [XLEN-1:0] mem_data;

    logic            issue_valid;
    reg_idx_t        issue_rd;
    reg_idx_t        rs1_q;
    reg_idx_t        rs2_q;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            rd_busy;

    reg_idx_t        wb_rd;
    logic [XLEN-1:0] write_back;
    logic            write_en;

    // Pipeline / decode side.
    modport master (
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        output issue_valid, issue_rd, rs1_q, rs2_q,
        input  alu_ready, mem_ready, rs1_busy, rs2_busy, rd_busy,
        input  wb_rd, write_back, write_en
    );

    // Writeback unit side.
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        input  issue_valid, issue_rd, rs1_q, rs2_q,
        output alu_ready, mem_ready, rs1_busy, rs2_busy, rd_busy,
        output wb_rd, write_back, write_en
    );

endinterface

// File: rtl/wb_result_fifo.sv
// Small FIFO of pending memory results; head is read combinationally from storage.
module wb_result_fifo
    import core_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  wb_result_t                   push_data,
    input  logic                         pop,
    output wb_result_t                   pop_data,
    output logic [$clog2(Depth+1)-1:0]   count
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    wb_result_t      mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;

    // Pointer and occupancy state; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/writeback_unit.sv
// Arbitrates ALU and memory results onto the register-file write port and
// tracks per-register outstanding writes for decode.
module writeback_unit
    import core_pkg::*;
#(
    parameter int unsigned MEM_DEPTH  = 4,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    writeback_unit_if.slave  bus
);

    localparam int unsigned CntW = $clog2(MEM_DEPTH + 1);
    localparam int unsigned StW  = $clog2(STARVE_MAX + 1);
    localparam logic [CntW-1:0] FullCnt   = CntW'(MEM_DEPTH);
    localparam logic [StW-1:0]  StarveLim = StW'(STARVE_MAX);

    logic [CntW-1:0] count;
    logic            fifo_nonempty;
    logic            fifo_force;
    logic            alu_ready;
    logic            mem_push;
    logic            grant_alu;
    logic            grant_fifo;

    wb_result_t      alu_res;
    wb_result_t      mem_res;
    wb_result_t      fifo_head;
    wb_result_t      sel_res;

    wb_result_t      wb_q;
    logic            we_q;
    logic [StW-1:0]  starve_q, starve_d;
    logic [NREG-1:0] busy_q, busy_d;

    assign alu_res = '{rd: bus.alu_rd, data: bus.alu_data};
    assign mem_res = '{rd: bus.mem_rd, data: bus.mem_data};

    // Full check uses registered count only, so a same-cycle pop never frees a slot early.
    assign mem_push = bus.mem_valid && (count < FullCnt);

    wb_result_fifo #(
        .Depth (MEM_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (mem_push),
        .push_data (mem_res),
        .pop       (grant_fifo),
        .pop_data  (fifo_head),
        .count     (count)
    );

    // Arbitration: ALU wins unless the FIFO is full or has been starved too long.
    always_comb begin
        fifo_nonempty = (count != '0);
        fifo_force    = (count == FullCnt) || (fifo_nonempty && (starve_q == StarveLim));
        alu_ready     = !fifo_force;
        grant_alu     = bus.alu_valid && alu_ready;
        grant_fifo    = fifo_nonempty && !grant_alu;
        sel_res       = grant_alu ? alu_res : fifo_head;
    end

    // Starve counter next state: counts ALU wins while memory results wait.
    always_comb begin
        starve_d = starve_q;
        if (grant_fifo || !fifo_nonempty) begin
            starve_d = '0;
        end else if (grant_alu && (starve_q != StarveLim)) begin
            starve_d = starve_q + StW'(1);
        end
    end

    // Scoreboard next state: clear on commit, then set on issue so a same-cycle set wins.
    always_comb begin
        busy_d = busy_q;
        if (we_q && busy_q[wb_q.rd]) busy_d[wb_q.rd] = 1'b0;
        if (bus.issue_valid && (bus.issue_rd != '0)) busy_d[bus.issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // Registered write port, starve counter and scoreboard.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_q     <= '0;
            we_q     <= 1'b0;
            starve_q <= '0;
            busy_q   <= '0;
        end else begin
            if (grant_alu || grant_fifo) begin
                wb_q <= sel_res;
                we_q <= (sel_res.rd != '0);
            end else begin
                we_q <= 1'b0;
            end
            starve_q <= starve_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.alu_ready  = alu_ready;
    assign bus.mem_ready  = (count < FullCnt);
    assign bus.wb_rd      = wb_q.rd;
    assign bus.write_back = wb_q.data;
    assign bus.write_en   = we_q;
    assign bus.rs1_busy   = busy_q[bus.rs1_q];
    assign bus.rs2_busy   = busy_q[bus.rs2_q];
    assign bus.rd_busy    = busy_q[bus.issue_rd];

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit.
module tb_writeback_unit;
    import core_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    logic waw_ok;

    writeback_unit_if bus ();

    writeback_unit #(
        .MEM_DEPTH  (4),
        .STARVE_MAX (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decode must never issue to a register that still has a write outstanding.
    always @(posedge clk) begin
        if (rst_n && !waw_ok) begin
            assert (!(bus.issue_valid && bus.rd_busy)) else begin
                n_err++;
                $error("FAIL waw: issue_rd=%0d observed busy=1 required 0", bus.issue_rd);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_wb(input string tag, input logic [4:0] rd, input logic [31:0] data);
        check({tag, "_en"}, 32'(bus.write_en), 32'd1);
        check({tag, "_rd"}, 32'(bus.wb_rd), 32'(rd));
        check({tag, "_data"}, bus.write_back, data);
    endtask

    initial begin
        n_cmp           = 0;
        n_err           = 0;
        waw_ok          = 1'b0;
        rst_n           = 1'b0;
        bus.alu_valid   = 1'b0;
        bus.alu_rd      = '0;
        bus.alu_data    = '0;
        bus.mem_valid   = 1'b0;
        bus.mem_rd      = '0;
        bus.mem_data    = '0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.rs1_q       = '0;
        bus.rs2_q       = '0;

        // Reset state.
        step();
        step();
        rst_n = 1'b1;
        check("rst_we", 32'(bus.write_en), 32'd0);
        check("rst_rd", 32'(bus.wb_rd), 32'd0);
        check("rst_data", bus.write_back, 32'd0);
        check("rst_mem_ready", 32'(bus.mem_ready), 32'd1);
        check("rst_alu_ready", 32'(bus.alu_ready), 32'd1);
        step();

        // 1: single ALU result, latency 1, then hold.
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd5;
        bus.alu_data  = 32'hDEADBEEF;
        check("t1_alu_ready", 32'(bus.alu_ready), 32'd1);
        step();
        bus.alu_valid = 1'b0;
        check_wb("t1_wb", 5'd5, 32'hDEADBEEF);
        step();
        check("t1_we_low", 32'(bus.write_en), 32'd0);
        check("t1_rd_hold", 32'(bus.wb_rd), 32'd5);
        check("t1_data_hold", bus.write_back, 32'hDEADBEEF);

        // 2: scoreboard set on issue, cleared by memory writeback.
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd7;
        bus.rs1_q       = 5'd7;
        bus.rs2_q       = 5'd7;
        #1;
        check("t2_rd_busy_pre", 32'(bus.rd_busy), 32'd0);
        check("t2_rs1_pre", 32'(bus.rs1_busy), 32'd0);
        step();
        bus.issue_valid = 1'b0;
        check("t2_rs1_set", 32'(bus.rs1_busy), 32'd1);
        check("t2_rs2_set", 32'(bus.rs2_busy), 32'd1);
        step();
        step();
        bus.mem_valid = 1'b1;
        bus.mem_rd    = 5'd7;
        bus.mem_data  = 32'h12345678;
        check("t2_mem_ready", 32'(bus.mem_ready), 32'd1);
        step();
        bus.mem_valid = 1'b0;
        check("t2_we_n1", 32'(bus.write_en), 32'd0);
        step();
        check_wb("t2_wb_n2", 5'd7, 32'h12345678);
        check("t2_rs1_still", 32'(bus.rs1_busy), 32'd1);
        step();
        check("t2_rs1_clr", 32'(bus.rs1_busy), 32'd0);
        check("t2_we_low", 32'(bus.write_en), 32'd0);

        // 3: fill the FIFO under continuous ALU traffic, then drain in order.
        for (int i = 0; i < 4; i++) begin
            bus.alu_valid = 1'b1;
            bus.alu_rd    = 5'd9;
            bus.alu_data  = 32'hA000_0000 + 32'(i);
            bus.mem_valid = 1'b1;
            bus.mem_rd    = 5'(10 + i);
            bus.mem_data  = 32'hB000_0000 + 32'(i);
            check("t3_alu_ready", 32'(bus.alu_ready), 32'd1);
            check("t3_mem_ready", 32'(bus.mem_ready), 32'd1);
            step();
            check_wb("t3_alu_wb", 5'd9, 32'hA000_0000 + 32'(i));
        end
        bus.mem_valid = 1'b0;
        bus.alu_data  = 32'hA000_0004;
        check("t3_full_mem_ready", 32'(bus.mem_ready), 32'd0);
        check("t3_full_alu_ready", 32'(bus.alu_ready), 32'd0);
        step();
        bus.alu_valid = 1'b0;
        check_wb("t3_drain0", 5'd10, 32'hB000_0000);
        for (int i = 1; i < 4; i++) begin
            step();
            check_wb("t3_drain", 5'(10 + i), 32'hB000_0000 + 32'(i));
        end
        step();
        check("t3_idle", 32'(bus.write_en), 32'd0);

        // Second burst: pointers cross the wrap point.
        for (int i = 0; i < 4; i++) begin
            bus.mem_valid = 1'b1;
            bus.mem_rd    = 5'(20 + i);
            bus.mem_data  = 32'hC000_0000 + 32'(i);
            step();
            if (i >= 1) check_wb("t3_wrap", 5'(19 + i), 32'hC000_0000 + 32'(i - 1));
        end
        bus.mem_valid = 1'b0;
        step();
        check_wb("t3_wrap3", 5'd23, 32'hC000_0003);
        step();
        check("t3_wrap_idle", 32'(bus.write_en), 32'd0);

        // 4: starvation limit forces one FIFO grant after four ALU wins.
        bus.mem_valid = 1'b1;
        bus.mem_rd    = 5'd12;
        bus.mem_data  = 32'hD000_0000;
        step();
        bus.mem_valid = 1'b0;
        check("t4_push_idle", 32'(bus.write_en), 32'd0);
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd11;
        for (int i = 0; i < 4; i++) begin
            bus.alu_data = 32'hE000_0000 + 32'(i);
            check("t4_alu_ready", 32'(bus.alu_ready), 32'd1);
            step();
            check_wb("t4_alu_wb", 5'd11, 32'hE000_0000 + 32'(i));
        end
        bus.alu_data = 32'hE000_0004;
        check("t4_starved", 32'(bus.alu_ready), 32'd0);
        step();
        check_wb("t4_fifo_wb", 5'd12, 32'hD000_0000);
        check("t4_resume_ready", 32'(bus.alu_ready), 32'd1);
        step();
        bus.alu_valid = 1'b0;
        check_wb("t4_resume_wb", 5'd11, 32'hE000_0004);
        step();

        // 5: x0 results are consumed without a write; busy bits unaffected.
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd4;
        #1;
        check("t5_rd_busy4_pre", 32'(bus.rd_busy), 32'd0);
        step();
        bus.issue_valid = 1'b0;
        bus.alu_valid   = 1'b1;
        bus.alu_rd      = 5'd0;
        bus.alu_data    = 32'h0000_0055;
        check("t5_alu0_ready", 32'(bus.alu_ready), 32'd1);
        step();
        bus.alu_valid = 1'b0;
        check("t5_alu0_we", 32'(bus.write_en), 32'd0);
        bus.mem_valid = 1'b1;
        bus.mem_rd    = 5'd0;
        bus.mem_data  = 32'h0000_0066;
        check("t5_mem0_ready", 32'(bus.mem_ready), 32'd1);
        step();
        bus.mem_valid = 1'b0;
        step();
        check("t5_mem0_we", 32'(bus.write_en), 32'd0);
        step();
        check("t5_mem0_drained", 32'(bus.write_en), 32'd0);
        bus.rs2_q = 5'd4;
        bus.rs1_q = 5'd0;
        #1;
        check("t5_busy4_kept", 32'(bus.rs2_busy), 32'd1);
        check("t5_busy0", 32'(bus.rs1_busy), 32'd0);

        // Same-edge set and clear on x3: set wins.
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd3;
        #1;
        check("t5_rd_busy3_pre", 32'(bus.rd_busy), 32'd0);
        step();
        bus.issue_valid = 1'b0;
        bus.alu_valid   = 1'b1;
        bus.alu_rd      = 5'd3;
        bus.alu_data    = 32'h0000_0033;
        step();
        bus.alu_valid = 1'b0;
        check_wb("t5_wb3", 5'd3, 32'h0000_0033);
        // The commit lands on the same edge as this reissue.
        waw_ok          = 1'b1;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd3;
        bus.rs1_q       = 5'd3;
        step();
        bus.issue_valid = 1'b0;
        waw_ok          = 1'b0;
        check("t5_set_wins", 32'(bus.rs1_busy), 32'd1);
        step();
        check("t5_set_sticks", 32'(bus.rs1_busy), 32'd1);

        // 6: reset mid-operation with FIFO entries, busy bits and write_en high.
        bus.alu_valid   = 1'b1;
        bus.alu_rd      = 5'd13;
        bus.alu_data    = 32'hF000_0000;
        bus.mem_valid   = 1'b1;
        bus.mem_rd      = 5'd15;
        bus.mem_data    = 32'h0F00_0000;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd14;
        #1;
        check("t6_rd_busy14_pre", 32'(bus.rd_busy), 32'd0);
        step();
        bus.issue_valid = 1'b0;
        step();
        step();
        bus.mem_valid = 1'b0;
        bus.rs1_q     = 5'd14;
        bus.rs2_q     = 5'd4;
        #1;
        check("t6_pre_we", 32'(bus.write_en), 32'd1);
        check("t6_pre_mem_ready", 32'(bus.mem_ready), 32'd1);
        check("t6_pre_busy14", 32'(bus.rs1_busy), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.alu_valid = 1'b0;
        check("t6_we", 32'(bus.write_en), 32'd0);
        check("t6_rd", 32'(bus.wb_rd), 32'd0);
        check("t6_data", bus.write_back, 32'd0);
        check("t6_mem_ready", 32'(bus.mem_ready), 32'd1);
        check("t6_alu_ready", 32'(bus.alu_ready), 32'd1);
        check("t6_busy14", 32'(bus.rs1_busy), 32'd0);
        check("t6_busy4", 32'(bus.rs2_busy), 32'd0);
        check("t6_rd_busy", 32'(bus.rd_busy), 32'd0);
        bus.rs1_q = 5'd3;
        #1;
        check("t6_busy3", 32'(bus.rs1_busy), 32'd0);
        step();
        check("t6_no_stale_pop", 32'(bus.write_en), 32'd0);
        step();
        check("t6_still_idle", 32'(bus.write_en), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
